// File: rtl/jtag_tap_multi_dr.sv
// JTAG TAP with a 16-state controller, a parametrised IR, and IDCODE/BYPASS registers.
// It also provides N_USER user data registers. All data registers share one shift
// register, and each user DR has its own capture input, update output and update strobe.
//
// state   | meaning
// --------+---------------------------------------------
// TLR     | test-logic-reset, IR forced to IDCODE
// RTI     | run-test/idle
// SEL_DR  | select DR scan
// CAP_DR  | parallel load of the active data register
// SH_DR   | shift active data register toward tdo
// EX1_DR  | exit-1 DR
// PAU_DR  | pause DR, shift register holds
// EX2_DR  | exit-2 DR, may resume shifting
// UPD_DR  | commit user DR and raise strobe
// SEL_IR  | select IR scan
// CAP_IR  | load 2'b01 pattern into IR shift register
// SH_IR   | shift IR
// EX1_IR  | exit-1 IR
// PAU_IR  | pause IR
// EX2_IR  | exit-2 IR
// UPD_IR  | commit new instruction
module jtag_tap_multi_dr #(
  parameter int          IR_WIDTH     = 4,
  parameter int          N_USER       = 2,
  parameter int          USER_DR_W    = 32,
  parameter logic [31:0] IDCODE_VAL   = 32'hBADC0FFE,
  parameter int          USER_IR_BASE = 4
) (
  input  logic                        tck,
  input  logic                        trst,
  input  logic                        tms,
  input  logic                        tdi,
  output logic                        tdo,
  output logic                        tdo_en,
  output logic [3:0]                  tap_state_o,
  output logic [IR_WIDTH-1:0]         ir_o,
  output logic [N_USER-1:0]           user_sel_o,
  input  logic [N_USER*USER_DR_W-1:0] user_capture_i,
  output logic [N_USER*USER_DR_W-1:0] user_update_o,
  output logic [N_USER-1:0]           user_update_valid_o
);

  localparam int DR_W = (USER_DR_W > 32) ? USER_DR_W : 32;

  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_t;

  tap_state_t                  state;
  logic [IR_WIDTH-1:0]         ir;
  logic [IR_WIDTH-1:0]         ir_shift;
  logic [DR_W-1:0]             dr_shift;
  logic [DR_W-1:0]             dr_capture;
  logic [DR_W-1:0]             dr_shifted;
  logic [N_USER*USER_DR_W-1:0] user_update_q;
  logic [N_USER-1:0]           user_update_valid_q;
  logic [N_USER-1:0]           user_sel;
  logic                        sel_idcode;

  function automatic tap_state_t next_state(input tap_state_t s, input logic m);
    case (s)
      TLR:     next_state = m ? TLR    : RTI;
      RTI:     next_state = m ? SEL_DR : RTI;
      SEL_DR:  next_state = m ? SEL_IR : CAP_DR;
      CAP_DR:  next_state = m ? EX1_DR : SH_DR;
      SH_DR:   next_state = m ? EX1_DR : SH_DR;
      EX1_DR:  next_state = m ? UPD_DR : PAU_DR;
      PAU_DR:  next_state = m ? EX2_DR : PAU_DR;
      EX2_DR:  next_state = m ? UPD_DR : SH_DR;
      UPD_DR:  next_state = m ? SEL_DR : RTI;
      SEL_IR:  next_state = m ? TLR    : CAP_IR;
      CAP_IR:  next_state = m ? EX1_IR : SH_IR;
      SH_IR:   next_state = m ? EX1_IR : SH_IR;
      EX1_IR:  next_state = m ? UPD_IR : PAU_IR;
      PAU_IR:  next_state = m ? EX2_IR : PAU_IR;
      EX2_IR:  next_state = m ? UPD_IR : SH_IR;
      UPD_IR:  next_state = m ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  endfunction

  // Instruction decode: IDCODE, user k, everything else (incl. all-ones) is bypass.
  always_comb begin
    sel_idcode = (ir == IR_WIDTH'(1));
    user_sel   = '0;
    for (int k = 0; k < N_USER; k++) begin
      user_sel[k] = (ir == IR_WIDTH'(USER_IR_BASE + k));
    end
  end

  // Capture value and one-step shift result of the shared DR for the active instruction.
  always_comb begin
    dr_capture = '0;
    if (sel_idcode) begin
      dr_capture = DR_W'(IDCODE_VAL);
    end else begin
      for (int k = 0; k < N_USER; k++) begin
        if (user_sel[k]) dr_capture = DR_W'(user_capture_i[k*USER_DR_W +: USER_DR_W]);
      end
    end

    dr_shifted = dr_shift >> 1;
    if (sel_idcode)      dr_shifted[31]          = tdi;
    else if (|user_sel)  dr_shifted[USER_DR_W-1] = tdi;
    else                 dr_shifted[0]           = tdi;
  end

  // TAP controller plus IR/DR datapath; strobes default low and pulse for one cycle.
  always_ff @(posedge tck) begin
    if (trst) begin
      state               <= TLR;
      ir                  <= IR_WIDTH'(1);
      ir_shift            <= '0;
      dr_shift            <= '0;
      user_update_q       <= '0;
      user_update_valid_q <= '0;
    end else begin
      state               <= next_state(state, tms);
      user_update_valid_q <= '0;
      case (state)
        TLR:    ir       <= IR_WIDTH'(1);
        CAP_IR: ir_shift <= IR_WIDTH'(2'b01);
        SH_IR:  ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
        UPD_IR: ir       <= ir_shift;
        CAP_DR: dr_shift <= dr_capture;
        SH_DR:  dr_shift <= dr_shifted;
        UPD_DR: begin
          for (int k = 0; k < N_USER; k++) begin
            if (user_sel[k]) begin
              user_update_q[k*USER_DR_W +: USER_DR_W] <= dr_shift[USER_DR_W-1:0];
              user_update_valid_q[k]                  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tdo = (state == SH_IR) ? ir_shift[0] :
               (state == SH_DR) ? dr_shift[0] : 1'b0;
  assign tdo_en              = (state == SH_IR) || (state == SH_DR);
  assign tap_state_o         = state;
  assign ir_o                = ir;
  assign user_sel_o          = user_sel;
  assign user_update_o       = user_update_q;
  assign user_update_valid_o = user_update_valid_q;

endmodule
